w_stage: RTL and testbench

Write-back stage of the five-stage pipeline. It registers the M-stage results, extends load data, selects the register-file write value and drives the GRF write port, the W-stage forwarding source and a retired-instruction counter. The GRF is written at the clock edge that ends each W cycle.

---
 rtl/w_stage_if.sv | 31 +++
 rtl/w_stage.sv | 123 ++++++++++++
 tb/tb_w_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/w_stage_if.sv
// rtl/w_stage_if.sv - M-to-W pipeline bundle and W-stage GRF/forwarding outputs
interface w_stage_if;
  logic        M_Valid;
  logic [31:0] M_PC;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDSel;
  logic [2:0]  M_LoadType;
  logic [31:0] M_ALUResult;
  logic [31:0] M_DMRD;
  logic [31:0] M_MDResult;

  logic        W_Valid;
  logic        W_GRF_RegWrite;
  logic [4:0]  W_GRF_A3;
  logic [31:0] W_GRF_RFWD;
  logic [31:0] W_GRF_PC;
  logic [31:0] W_RetireCnt;

  modport master (
    output M_Valid, M_PC, M_RegWrite, M_A3, M_WDSel, M_LoadType,
           M_ALUResult, M_DMRD, M_MDResult,
    input  W_Valid, W_GRF_RegWrite, W_GRF_A3, W_GRF_RFWD, W_GRF_PC, W_RetireCnt
  );

  modport slave (
    input  M_Valid, M_PC, M_RegWrite, M_A3, M_WDSel, M_LoadType,
           M_ALUResult, M_DMRD, M_MDResult,
    output W_Valid, W_GRF_RegWrite, W_GRF_A3, W_GRF_RFWD, W_GRF_PC, W_RetireCnt
  );
endinterface

// File: rtl/w_stage.sv
// rtl/w_stage.sv - write-back stage: W register, load extension, RFWD mux, retire counter
// Optional sub-word load extension enabled by defining W_LOAD_EXT_EN.
module w_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic   Clk,
  input logic   Reset,
  w_stage_if.slave wif
);

  logic        valid_q,    valid_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  a3_q,       a3_d;
  logic [1:0]  wdsel_q,    wdsel_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] alu_q,      alu_d;
  logic [31:0] dmrd_q,     dmrd_d;
  logic [31:0] md_q,       md_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] load_data;
  logic [31:0] rfwd;

  always_comb begin
    valid_d      = wif.M_Valid;
    regwrite_d   = wif.M_Valid & wif.M_RegWrite;
    a3_d         = wif.M_A3;
    wdsel_d      = wif.M_WDSel;
    pc_d         = wif.M_PC;
    alu_d        = wif.M_ALUResult;
    dmrd_d       = wif.M_DMRD;
    md_d         = wif.M_MDResult;
    // Counts the instruction leaving W at this edge, not the one arriving.
    retire_cnt_d = retire_cnt_q + {31'd0, valid_q};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      a3_q         <= 5'd0;
      wdsel_q      <= 2'd0;
      pc_q         <= RESET_PC;
      alu_q        <= 32'd0;
      dmrd_q       <= 32'd0;
      md_q         <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      a3_q         <= a3_d;
      wdsel_q      <= wdsel_d;
      pc_q         <= pc_d;
      alu_q        <= alu_d;
      dmrd_q       <= dmrd_d;
      md_q         <= md_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef W_LOAD_EXT_EN
  logic [2:0]  loadtype_q, loadtype_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    loadtype_d = wif.M_LoadType;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      loadtype_q <= 3'd0;
    end else begin
      loadtype_q <= loadtype_d;
    end
  end

  always_comb begin
    byte_sel = 8'd0;
    case (alu_q[1:0])
      2'd0:    byte_sel = dmrd_q[7:0];
      2'd1:    byte_sel = dmrd_q[15:8];
      2'd2:    byte_sel = dmrd_q[23:16];
      default: byte_sel = dmrd_q[31:24];
    endcase
    // Halfword alignment is checked upstream; only off[1] picks the half.
    half_sel = alu_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
    load_data = dmrd_q;
    case (loadtype_q)
      3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    load_data = {24'd0, byte_sel};
      3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {16'd0, half_sel};
      default: load_data = dmrd_q;
    endcase
  end
`else
  logic [2:0] unused_loadtype;

  assign unused_loadtype = wif.M_LoadType;

  always_comb begin
    load_data = dmrd_q;
  end
`endif

  always_comb begin
    rfwd = alu_q;
    case (wdsel_q)
      2'd0:    rfwd = alu_q;
      2'd1:    rfwd = load_data;
      2'd2:    rfwd = pc_q + 32'd8;
      default: rfwd = md_q;
    endcase
  end

  assign wif.W_Valid        = valid_q;
  assign wif.W_GRF_RegWrite = valid_q & regwrite_q & (a3_q != 5'd0);
  assign wif.W_GRF_A3       = a3_q;
  assign wif.W_GRF_RFWD     = rfwd;
  assign wif.W_GRF_PC       = pc_q;
  assign wif.W_RetireCnt    = retire_cnt_q;

endmodule

// File: tb/tb_w_stage.sv
// tb/tb_w_stage.sv - directed self-checking bench for w_stage
module tb_w_stage;
  logic Clk;
  logic Reset;
  int   vectors;
  int   miscompares;

  w_stage_if wif ();

  w_stage #(.RESET_PC(32'h0000_3000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .wif   (wif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] a3,
                       input logic [1:0] wdsel, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] dmrd,
                       input logic [31:0] md, input logic [31:0] pc);
    wif.M_Valid     = v;
    wif.M_RegWrite  = rw;
    wif.M_A3        = a3;
    wif.M_WDSel     = wdsel;
    wif.M_LoadType  = lt;
    wif.M_ALUResult = alu;
    wif.M_DMRD      = dmrd;
    wif.M_MDResult  = md;
    wif.M_PC        = pc;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset = 1'b1;
    wif.M_Valid = 1'b0; wif.M_RegWrite = 1'b0; wif.M_A3 = 5'd0; wif.M_WDSel = 2'd0;
    wif.M_LoadType = 3'd0; wif.M_ALUResult = 32'd0; wif.M_DMRD = 32'd0;
    wif.M_MDResult = 32'd0; wif.M_PC = 32'd0;
    #12;
    check("rst_valid", {31'd0, wif.W_Valid}, 32'd0);
    check("rst_regwrite", {31'd0, wif.W_GRF_RegWrite}, 32'd0);
    check("rst_a3", {27'd0, wif.W_GRF_A3}, 32'd0);
    check("rst_rfwd", wif.W_GRF_RFWD, 32'd0);
    check("rst_pc", wif.W_GRF_PC, 32'h0000_3000);
    check("rst_cnt", wif.W_RetireCnt, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    drive(1, 1, 5'd8, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 32'h0000_3000);
    check("alu_regwrite", {31'd0, wif.W_GRF_RegWrite}, 32'd1);
    check("alu_a3", {27'd0, wif.W_GRF_A3}, 32'd8);
    check("alu_rfwd", wif.W_GRF_RFWD, 32'h1234_5678);
    check("alu_cnt", wif.W_RetireCnt, 32'd0);

`ifdef W_LOAD_EXT_EN
    drive(1, 1, 5'd9, 2'd1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'd0, 32'h0000_3004);
    check("lb_off3", wif.W_GRF_RFWD, 32'hFFFF_FF80);
    drive(1, 1, 5'd9, 2'd1, 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'd0, 32'h0000_3008);
    check("lbu_off2", wif.W_GRF_RFWD, 32'h0000_00FF);
    drive(1, 1, 5'd9, 2'd1, 3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'd0, 32'h0000_300C);
    check("lh_off2", wif.W_GRF_RFWD, 32'hFFFF_80FF);
    drive(1, 1, 5'd9, 2'd1, 3'd4, 32'h0000_1000, 32'h80FF_7F01, 32'd0, 32'h0000_3010);
    check("lhu_off0", wif.W_GRF_RFWD, 32'h0000_7F01);
`else
    drive(1, 1, 5'd9, 2'd1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'd0, 32'h0000_3004);
    check("lb_raw", wif.W_GRF_RFWD, 32'h80FF_7F01);
    drive(1, 1, 5'd9, 2'd1, 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'd0, 32'h0000_3008);
    check("lbu_raw", wif.W_GRF_RFWD, 32'h80FF_7F01);
    drive(1, 1, 5'd9, 2'd1, 3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'd0, 32'h0000_300C);
    check("lh_raw", wif.W_GRF_RFWD, 32'h80FF_7F01);
    drive(1, 1, 5'd9, 2'd1, 3'd4, 32'h0000_1000, 32'h80FF_7F01, 32'd0, 32'h0000_3010);
    check("lhu_raw", wif.W_GRF_RFWD, 32'h80FF_7F01);
`endif
    check("load_cnt", wif.W_RetireCnt, 32'd4);

    drive(1, 1, 5'd31, 2'd2, 3'd0, 32'h5555_5555, 32'd0, 32'd0, 32'h0000_3010);
    check("jal_rfwd", wif.W_GRF_RFWD, 32'h0000_3018);
    check("jal_pc", wif.W_GRF_PC, 32'h0000_3010);
    drive(1, 1, 5'd31, 2'd2, 3'd0, 32'h5555_5555, 32'd0, 32'd0, 32'hFFFF_FFFC);
    check("jal_wrap", wif.W_GRF_RFWD, 32'h0000_0004);
    drive(1, 1, 5'd4, 2'd3, 3'd0, 32'h5555_5555, 32'd0, 32'hDEAD_BEEF, 32'h0000_3020);
    check("md_rfwd", wif.W_GRF_RFWD, 32'hDEAD_BEEF);

    drive(1, 1, 5'd0, 2'd0, 3'd0, 32'h0000_0001, 32'd0, 32'd0, 32'h0000_3024);
    check("a3zero_regwrite", {31'd0, wif.W_GRF_RegWrite}, 32'd0);
    check("a3zero_valid", {31'd0, wif.W_Valid}, 32'd1);
    drive(0, 1, 5'd5, 2'd0, 3'd0, 32'h0000_0002, 32'd0, 32'd0, 32'h0000_3028);
    check("bubble_regwrite", {31'd0, wif.W_GRF_RegWrite}, 32'd0);
    check("bubble_valid", {31'd0, wif.W_Valid}, 32'd0);
    check("bubble_cnt", wif.W_RetireCnt, 32'd9);

    drive(1, 1, 5'd3, 2'd0, 3'd0, 32'h0000_00AA, 32'd0, 32'd0, 32'h0000_302C);
    check("pre_rst_regwrite", {31'd0, wif.W_GRF_RegWrite}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_regwrite", {31'd0, wif.W_GRF_RegWrite}, 32'd0);
    check("midrst_valid", {31'd0, wif.W_Valid}, 32'd0);
    check("midrst_pc", wif.W_GRF_PC, 32'h0000_3000);
    check("midrst_cnt", wif.W_RetireCnt, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) drive(1, 1, 5'd1, 2'd0, 3'd0, i, 32'd0, 32'd0, 32'h0000_3000);
    for (int i = 0; i < 2; i++) drive(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000);
    for (int i = 0; i < 3; i++) drive(1, 1, 5'd1, 2'd0, 3'd0, i, 32'd0, 32'd0, 32'h0000_3000);
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000);
    check("retire_8", wif.W_RetireCnt, 32'd8);

    drive(1, 1, 5'd2, 2'd0, 3'd0, 32'd7, 32'd0, 32'd0, 32'h0000_3000);
    #2;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    check("preload_cnt", wif.W_RetireCnt, 32'hFFFF_FFFF);
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'h0000_3000);
    check("retire_wrap", wif.W_RetireCnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
